fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 135 +++++++++++++
 tb/tb_fetch_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues fetch requests to a zero-wait-capable
// instruction memory, buffers up to two returned words with their addresses,
// handles branch redirects (including a request already in flight), and stops
// fetching after a halt opcode until the next redirect.
module fetch_queue #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] BUBBLE   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] instr_pc,
  output logic [15:0] instr_pc_plus2,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH,
    DROP,
    HALTED
  } state_t;

  state_t      state;
  logic [1:0]  count;
  logic [15:0] q_word [2];
  logic [15:0] q_pc   [2];
  logic [15:0] fetch_pc;
  logic [15:0] drop_addr;

  logic        push;
  logic        pop;
  logic [15:0] br_addr;

  // Request/queue-head outputs and the push/pop decisions for this cycle.
  always_comb begin
    mem_req        = 1'b0;
    mem_addr       = fetch_pc;
    instr_valid    = (count != 2'd0);
    instr          = BUBBLE;
    instr_pc       = '0;
    halted         = (state == HALTED) && (count == 2'd0);
    br_addr        = {br_target[15:1], 1'b0};
    case (state)
      FETCH:   mem_req = (count < 2'd2);
      DROP: begin
        mem_req  = 1'b1;
        mem_addr = drop_addr;
      end
      default: mem_req = 1'b0;
    endcase
    if (instr_valid) begin
      instr    = q_word[0];
      instr_pc = q_pc[0];
    end
    instr_pc_plus2 = instr_pc + 16'd2;
    push = (state == FETCH) && mem_req && mem_ready && !br_taken;
    pop  = instr_valid && !stall && !br_taken;
  end

  // FSM, fetch address and two-entry queue; a redirect overrides everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      count     <= '0;
      fetch_pc  <= RESET_PC;
      drop_addr <= '0;
      q_word[0] <= '0;
      q_word[1] <= '0;
      q_pc[0]   <= '0;
      q_pc[1]   <= '0;
    end else if (br_taken) begin
      count    <= '0;
      fetch_pc <= br_addr;
      case (state)
        FETCH: begin
          // A request still waiting on memory must be retired before refetching.
          if (mem_req && !mem_ready) begin
            state     <= DROP;
            drop_addr <= fetch_pc;
          end else begin
            state <= FETCH;
          end
        end
        DROP:    state <= mem_ready ? FETCH : DROP;
        default: state <= FETCH;
      endcase
    end else begin
      if (pop && push) begin
        // Entry 1 (if any) moves to the head; the new word lands behind it.
        if (count == 2'd1) begin
          q_word[0] <= mem_rdata;
          q_pc[0]   <= fetch_pc;
        end else begin
          q_word[0] <= q_word[1];
          q_pc[0]   <= q_pc[1];
          q_word[1] <= mem_rdata;
          q_pc[1]   <= fetch_pc;
        end
      end else if (pop) begin
        q_word[0] <= q_word[1];
        q_pc[0]   <= q_pc[1];
        count     <= count - 2'd1;
      end else if (push) begin
        if (count == 2'd0) begin
          q_word[0] <= mem_rdata;
          q_pc[0]   <= fetch_pc;
        end else begin
          q_word[1] <= mem_rdata;
          q_pc[1]   <= fetch_pc;
        end
        count <= count + 2'd1;
      end

      if (push) begin
        fetch_pc <= fetch_pc + 16'd2;
        if (mem_rdata[15:12] == 4'hF) begin
          state <= HALTED;
        end
      end

      if ((state == DROP) && mem_ready) begin
        state <= FETCH;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming fetch, stall back-pressure,
// redirect with an outstanding request, halt/resume, address wrap and
// asynchronous reset during a dropped request.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] instr_pc;
  logic [15:0] instr_pc_plus2;
  logic        halted;

  int unsigned n_tests;
  int unsigned n_fail;

  localparam logic [15:0] BUB = 16'hDEAD;

  fetch_queue #(
    .RESET_PC(16'h0000),
    .BUBBLE  (BUB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc),
    .instr_pc_plus2(instr_pc_plus2),
    .halted        (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic [15:0] tgt,
                       input logic rdy, input logic [15:0] rd);
    stall     = st;
    br_taken  = br;
    br_target = tgt;
    mem_ready = rdy;
    mem_rdata = rd;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [15:0] w,
                            input logic [15:0] pc);
    check({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, v});
    check({tag, "_instr"}, {16'd0, instr}, {16'd0, w});
    check({tag, "_pc"}, {16'd0, instr_pc}, {16'd0, pc});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_head(tag, 1'b0, BUB, 16'h0000);
    check({tag, "_pc2"}, {16'd0, instr_pc_plus2}, 32'h0000_0002);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_addr"}, {16'd0, mem_addr}, 32'h0000_0000);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    check_reset_outputs("rst");
    step();
    step();
    rst = 1'b0;

    // Zero-wait streaming
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234);
    check("s1_req", {31'd0, mem_req}, 32'd1);
    check("s1_addr", {16'd0, mem_addr}, 32'h0000);
    step();
    check_head("s1_w0", 1'b1, 16'h1234, 16'h0000);
    check("s1_pc2", {16'd0, instr_pc_plus2}, 32'h0002);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5678);
    check("s1_addr2", {16'd0, mem_addr}, 32'h0002);
    step();
    check_head("s1_w1", 1'b1, 16'h5678, 16'h0002);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    check("s1_addr3", {16'd0, mem_addr}, 32'h0004);
    step();
    check_head("s1_empty", 1'b0, BUB, 16'h0000);

    // Stall fills the queue, request drops when full
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'hAAAA);
    check("s2_addr0", {16'd0, mem_addr}, 32'h0004);
    step();
    check_head("s2_q1", 1'b1, 16'hAAAA, 16'h0004);
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'hBBBB);
    check("s2_addr1", {16'd0, mem_addr}, 32'h0006);
    step();
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'hCCCC);
    check("s2_full_req", {31'd0, mem_req}, 32'd0);
    step();
    check_head("s2_held", 1'b1, 16'hAAAA, 16'h0004);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    check("s2_full_req2", {31'd0, mem_req}, 32'd0);
    step();
    check_head("s2_pop1", 1'b1, 16'hBBBB, 16'h0006);
    check("s2_req_again", {31'd0, mem_req}, 32'd1);
    check("s2_addr_again", {16'd0, mem_addr}, 32'h0008);
    step();
    check("s2_drained", {31'd0, instr_valid}, 32'd0);

    // Redirect with same-cycle return: word discarded, target bit 0 cleared
    drive(1'b0, 1'b1, 16'h0003, 1'b1, 16'h1111);
    step();
    check("s3_valid", {31'd0, instr_valid}, 32'd0);
    check("s3_addr", {16'd0, mem_addr}, 32'h0002);

    // Redirect while a request to 0004 is outstanding
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h2222);
    step();
    check_head("s4_q", 1'b1, 16'h2222, 16'h0002);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    check("s4_addr", {16'd0, mem_addr}, 32'h0004);
    step();
    drive(1'b0, 1'b1, 16'h0041, 1'b0, 16'h0000);
    step();
    check("s4_flush", {31'd0, instr_valid}, 32'd0);
    check("s4_drop_req", {31'd0, mem_req}, 32'd1);
    check("s4_drop_addr", {16'd0, mem_addr}, 32'h0004);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    step();
    check("s4_drop_hold", {16'd0, mem_addr}, 32'h0004);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h3333);
    check("s4_drop_hold2", {16'd0, mem_addr}, 32'h0004);
    step();
    check("s4_dropped", {31'd0, instr_valid}, 32'd0);
    check("s4_new_req", {31'd0, mem_req}, 32'd1);
    check("s4_new_addr", {16'd0, mem_addr}, 32'h0040);

    // Halt opcode and resume
    drive(1'b1, 1'b1, 16'h0006, 1'b1, 16'h0777);
    step();
    check("s5_addr", {16'd0, mem_addr}, 32'h0006);
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'hF000);
    step();
    check_head("s5_halt_q", 1'b1, 16'hF000, 16'h0006);
    check("s5_no_req", {31'd0, mem_req}, 32'd0);
    check("s5_not_halted", {31'd0, halted}, 32'd0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1999);
    step();
    check("s5_empty", {31'd0, instr_valid}, 32'd0);
    check("s5_halted", {31'd0, halted}, 32'd1);
    check("s5_no_req2", {31'd0, mem_req}, 32'd0);
    drive(1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000);
    step();
    check("s5_resume_h", {31'd0, halted}, 32'd0);
    check("s5_resume_req", {31'd0, mem_req}, 32'd1);
    check("s5_resume_addr", {16'd0, mem_addr}, 32'h0010);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1010);
    step();
    check_head("s5_w", 1'b1, 16'h1010, 16'h0010);

    // Fetch address wrap
    drive(1'b1, 1'b1, 16'hFFFE, 1'b1, 16'h0888);
    step();
    check("s6_addr", {16'd0, mem_addr}, 32'hFFFE);
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'hABCD);
    step();
    check_head("s6_w", 1'b1, 16'hABCD, 16'hFFFE);
    check("s6_pc2", {16'd0, instr_pc_plus2}, 32'h0000);
    check("s6_wrap_addr", {16'd0, mem_addr}, 32'h0000);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0202);
    step();
    check_head("s6_w2", 1'b1, 16'h0202, 16'h0000);

    // Asynchronous reset while dropping a request
    drive(1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000);
    step();
    check("s7_drop_addr", {16'd0, mem_addr}, 32'h0002);
    check("s7_drop_valid", {31'd0, instr_valid}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("s7_rst");
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555);
    check("s7_first_req", {31'd0, mem_req}, 32'd1);
    check("s7_first_addr", {16'd0, mem_addr}, 32'h0000);
    step();
    check_head("s7_first_w", 1'b1, 16'h5555, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
